// File: rtl/video_clock_pkg.sv
// Shared definitions for the video clocking blocks: sequencer states and
// default timing for the 27 MHz reference.
package video_clock_pkg;

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        RUN
    } seq_state_t;

    localparam int unsigned DEF_PLL_RESET_CYCLES    = 27;      // 1 us
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 27000;   // 1 ms
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 270000;  // 10 ms
    localparam int unsigned DEF_LOSS_FILTER_CYCLES  = 4;

    function automatic int unsigned max_cycles(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c,
                                               input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signals between the PLL reset sequencer, the PLL and the downstream
// pixel/TMDS reset consumers.
interface pll_reset_sequencer_if;

    logic       pll_lock;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic [7:0] relock_count;
    logic       timeout_err;

    modport slave (
        input  pll_lock,
        output pll_reset,
        output sys_reset,
        output ready,
        output relock_count,
        output timeout_err
    );

    modport master (
        output pll_lock,
        input  pll_reset,
        input  sys_reset,
        input  ready,
        input  relock_count,
        input  timeout_err
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous status inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: synchronizer flops carry no reset; they settle within two cycles
    // of any input and a reset path would only add logic in front of meta.
    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL reset, waits for a stable synchronized lock, then releases the
// pixel/TMDS reset; re-runs the PLL reset sequence on lock loss.
module pll_reset_sequencer
    import video_clock_pkg::*;
#(
    parameter int unsigned PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned LOSS_FILTER_CYCLES  = DEF_LOSS_FILTER_CYCLES
) (
    input logic                  clk,
    input logic                  reset,
    pll_reset_sequencer_if.slave bus
);

    localparam int unsigned MAX_CYCLES = max_cycles(PLL_RESET_CYCLES, LOCK_STABLE_CYCLES,
                                                    LOCK_TIMEOUT_CYCLES, LOSS_FILTER_CYCLES);
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOSS_FILTER_CYCLES - 1);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       relock_q, relock_nxt;
    logic             timeout_q, timeout_nxt;
    logic             pll_reset_q, sys_reset_q, ready_q;
    logic             lock_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .d   (bus.pll_lock),
        .q   (lock_s)
    );

    // NOTE: every variable gets its default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        relock_nxt  = relock_q;
        timeout_nxt = timeout_q;

        unique case (state)
            RESET_PLL: begin
                if (cnt == RESET_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABILIZE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt   = RESET_PLL;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                // Counter tracks the current run of low lock samples only.
                if (lock_s) begin
                    cnt_nxt = '0;
                end else if (cnt == FILTER_LAST) begin
                    state_nxt  = RESET_PLL;
                    cnt_nxt    = '0;
                    relock_nxt = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                end
            end
            default: begin
                state_nxt = RESET_PLL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            relock_q    <= '0;
            timeout_q   <= 1'b0;
            pll_reset_q <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            relock_q    <= relock_nxt;
            timeout_q   <= timeout_nxt;
            // Decoded from the next state so outputs switch with the state.
            pll_reset_q <= (state_nxt == RESET_PLL);
            sys_reset_q <= (state_nxt != RUN);
            ready_q     <= (state_nxt == RUN);
        end
    end

    assign bus.pll_reset    = pll_reset_q;
    assign bus.sys_reset    = sys_reset_q;
    assign bus.ready        = ready_q;
    assign bus.relock_count = relock_q;
    assign bus.timeout_err  = timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus random
// lock patterns, compared every cycle against a countdown-based model.
module tb_pll_reset_sequencer;

    localparam int N  = 4;
    localparam int M  = 8;
    localparam int TO = 20;
    localparam int F  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    pll_reset_sequencer_if bus ();

    pll_reset_sequencer #(
        .PLL_RESET_CYCLES    (N),
        .LOCK_STABLE_CYCLES  (M),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOSS_FILTER_CYCLES  (F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: lock seen two edges late; hold/wait windows are
    // countdowns, settling counts consecutive good lock samples.
    logic [1:0] hist = 2'b00;
    logic       lk;
    int         hold_left  = 0;
    int         wait_left  = 0;
    int         stable_got = 0;
    int         low_run    = 0;
    int         m_rel      = 0;
    bit         live       = 1'b0;
    bit         m_tmo      = 1'b0;

    assign lk = hist[1];

    always @(posedge clk) begin
        hist <= {hist[0], bus.pll_lock};
        if (reset) begin
            hold_left  <= N;
            wait_left  <= TO;
            stable_got <= 0;
            low_run    <= 0;
            live       <= 1'b0;
            m_rel      <= 0;
            m_tmo      <= 1'b0;
        end else if (hold_left > 0) begin
            hold_left <= hold_left - 1;
            if (hold_left == 1) begin
                wait_left  <= TO;
                stable_got <= 0;
            end
        end else if (live) begin
            if (lk) low_run <= 0;
            else if (low_run + 1 == F) begin
                low_run   <= 0;
                live      <= 1'b0;
                hold_left <= N;
                m_rel     <= (m_rel < 255) ? m_rel + 1 : 255;
            end else low_run <= low_run + 1;
        end else if (stable_got > 0) begin
            if (!lk) begin
                stable_got <= 0;
                wait_left  <= TO;
            end else if (stable_got == M) begin
                live       <= 1'b1;
                low_run    <= 0;
                stable_got <= 0;
            end else stable_got <= stable_got + 1;
        end else if (lk) stable_got <= 1;
        else if (wait_left == 1) begin
            m_tmo     <= 1'b1;
            hold_left <= N;
        end else wait_left <= wait_left - 1;
    end

    logic [11:0] exp_vec, dut_vec;
    assign exp_vec = {hold_left != 0, !live, live, 8'(m_rel), m_tmo};
    assign dut_vec = {bus.pll_reset, bus.sys_reset, bus.ready, bus.relock_count, bus.timeout_err};

    task automatic test_reset();
        reset = 1'b1;
        bus.pll_lock = 1'b1;
        repeat (4) @(negedge clk);
        compared++;
        if (dut_vec !== 12'hC00) begin
            mismatched++;
            $display("FAIL reset_values dut=%h required=%h", dut_vec, 12'hC00);
        end
        compared++;
        if (dut_vec !== exp_vec) begin
            mismatched++;
            $display("FAIL reset_model dut=%h model=%h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_nominal();
        reset = 1'b0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            compared++;
            if (dut_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL nominal k=%0d dut=%h model=%h", k, dut_vec, exp_vec);
            end
            compared++;
            if (bus.pll_reset !== (k < N - 1) || bus.ready !== (k >= N + M) ||
                bus.sys_reset !== (k < N + M) || bus.relock_count !== 8'd0) begin
                mismatched++;
                $display("FAIL nominal_timing k=%0d pll_reset=%b ready=%b sys_reset=%b relock=%0d",
                         k, bus.pll_reset, bus.ready, bus.sys_reset, bus.relock_count);
            end
        end
    endtask

    task automatic test_stabilize_glitch();
        int first_ready = -1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            compared++;
            if (dut_vec !== exp_vec || bus.timeout_err !== 1'b0) begin
                mismatched++;
                $display("FAIL glitch k=%0d dut=%h model=%h", k, dut_vec, exp_vec);
            end
            if (bus.ready === 1'b1 && first_ready < 0) first_ready = k;
            if (k == 7) bus.pll_lock = 1'b0;
            if (k == 8) bus.pll_lock = 1'b1;
        end
        compared++;
        if (first_ready != 19) begin
            mismatched++;
            $display("FAIL glitch_ready_edge got=%0d required=19", first_ready);
        end
    endtask

    task automatic test_timeout();
        int rises = 0;
        logic prev = 1'b1;
        reset = 1'b1;
        bus.pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            compared++;
            if (dut_vec !== exp_vec || bus.ready !== 1'b0 || bus.timeout_err !== (k >= 23)) begin
                mismatched++;
                $display("FAIL timeout k=%0d dut=%h model=%h", k, dut_vec, exp_vec);
            end
            if (bus.pll_reset === 1'b1 && prev === 1'b0) rises++;
            prev = bus.pll_reset;
        end
        compared++;
        if (rises != 4) begin
            mismatched++;
            $display("FAIL timeout_retries got=%0d required=4", rises);
        end
        bus.pll_lock = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            compared++;
            if (dut_vec !== exp_vec || bus.timeout_err !== 1'b1) begin
                mismatched++;
                $display("FAIL timeout_recover k=%0d dut=%h model=%h", k, dut_vec, exp_vec);
            end
        end
        compared++;
        if (bus.ready !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_relock ready=%b required=1", bus.ready);
        end
    endtask

    task automatic test_loss_filter();
        int   drops = 0;
        logic prev  = 1'b1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            compared++;
            if (dut_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL loss j=%0d dut=%h model=%h", j, dut_vec, exp_vec);
            end
            if (prev === 1'b1 && bus.ready === 1'b0) begin
                drops++;
                compared++;
                if (j != 20 || bus.pll_reset !== 1'b1 || bus.sys_reset !== 1'b1 ||
                    bus.relock_count !== 8'd1) begin
                    mismatched++;
                    $display("FAIL loss_event j=%0d pll_reset=%b sys_reset=%b relock=%0d",
                             j, bus.pll_reset, bus.sys_reset, bus.relock_count);
                end
            end
            prev = bus.ready;
            bus.pll_lock = !(j < 2 || (j >= 15 && j < 18));
        end
        compared++;
        if (drops != 1 || bus.ready !== 1'b1 || bus.relock_count !== 8'd1) begin
            mismatched++;
            $display("FAIL loss_summary drops=%0d ready=%b relock=%0d required 1/1/1",
                     drops, bus.ready, bus.relock_count);
        end
    endtask

    task automatic test_saturation();
        int guard;
        for (int ev = 0; ev < 257; ev++) begin
            guard = 0;
            while (bus.ready !== 1'b1 && guard < 60) begin
                @(negedge clk);
                guard++;
                compared++;
                if (dut_vec !== exp_vec) begin
                    mismatched++;
                    $display("FAIL sat_relock ev=%0d dut=%h model=%h", ev, dut_vec, exp_vec);
                end
            end
            if (bus.ready !== 1'b1) begin
                compared++;
                mismatched++;
                $display("FAIL sat_wait_ready ev=%0d ready=%b required=1", ev, bus.ready);
                return;
            end
            bus.pll_lock = 1'b0;
            repeat (3) @(negedge clk);
            bus.pll_lock = 1'b1;
            guard = 0;
            while (bus.ready !== 1'b0 && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            compared++;
            if (dut_vec !== exp_vec) begin
                mismatched++;
                $display("FAIL sat_event ev=%0d dut=%h model=%h", ev, dut_vec, exp_vec);
            end
        end
        guard = 0;
        while (bus.ready !== 1'b1 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        compared++;
        if (bus.relock_count !== 8'd255 || bus.ready !== 1'b1) begin
            mismatched++;
            $display("FAIL saturation relock=%0d ready=%b required 255/1",
                     bus.relock_count, bus.ready);
        end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (dut_vec !== 12'hC00) begin
            mismatched++;
            $display("FAIL midrun_reset dut=%h required=%h", dut_vec, 12'hC00);
        end
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            compared++;
            if (dut_vec !== exp_vec || bus.ready !== (k >= N + M) || bus.pll_reset !== (k < N - 1)) begin
                mismatched++;
                $display("FAIL midrun_seq k=%0d dut=%h model=%h", k, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        int  k = 0;
        int  len;
        bit  lvl;
        while (k < 2000) begin
            lvl = ($urandom_range(0, 3) != 0);
            len = lvl ? $urandom_range(1, 40) : $urandom_range(1, 6);
            if (!lvl && $urandom_range(0, 9) == 0) len = 30;
            bus.pll_lock = lvl;
            repeat (len) begin
                @(negedge clk);
                k++;
                compared++;
                if (dut_vec !== exp_vec) begin
                    mismatched++;
                    $display("FAIL random k=%0d dut=%h model=%h", k, dut_vec, exp_vec);
                end
            end
            if ($urandom_range(0, 30) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                compared++;
                if (dut_vec !== exp_vec) begin
                    mismatched++;
                    $display("FAIL random_reset k=%0d dut=%h model=%h", k, dut_vec, exp_vec);
                end
            end
        end
    endtask

    initial begin
        bus.pll_lock = 1'b1;
        test_reset();
        test_nominal();
        test_stabilize_glitch();
        test_timeout();
        test_loss_filter();
        test_saturation();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
